// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Brief    : Circular fetch buffer between the instruction fetcher and decoder.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clr_in,
  input  logic               if_to_iq_ready,
  input  logic [31:0]        if_to_iq_PC,
  input  logic [6:0]         if_to_iq_opType,
  input  logic [31:0]        if_to_iq_inst,
  input  logic               if_to_iq_pred_br,
  output logic               iq_to_if_stall,
  input  logic               dc_to_iq_ready,
  output logic               iq_to_dc_valid,
  output logic [31:0]        iq_to_dc_PC,
  output logic [6:0]         iq_to_dc_opType,
  output logic [31:0]        iq_to_dc_inst,
  output logic               iq_to_dc_pred_br,
  output logic [PTR_W:0]     iq_count
);

  localparam int             c_ENTRY_W = 72;
  localparam logic [PTR_W:0] c_FULL    = (PTR_W+1)'(DEPTH);

  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W:0]       r_count;

  logic                 w_full;
  logic                 w_valid;
  logic                 w_push;
  logic                 w_pop;
  logic [c_ENTRY_W-1:0] w_head_entry;

  // Stall depends only on occupancy, keeping decoder ready off the fetcher path.
  assign w_full  = (r_count == c_FULL);
  assign w_valid = (r_count != '0);
  assign w_push  = rdy_in & ~clr_in & if_to_iq_ready & ~w_full;
  assign w_pop   = rdy_in & ~clr_in & w_valid & dc_to_iq_ready;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PTR_W'(1);
        if (w_pop)  r_head <= r_head + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset; validity is tracked entirely by the count.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_tail] <= {if_to_iq_pred_br, if_to_iq_opType, if_to_iq_inst, if_to_iq_PC};
    end
  end

  assign w_head_entry = r_mem[r_head];

  assign iq_to_if_stall   = w_full;
  assign iq_to_dc_valid   = w_valid;
  assign iq_to_dc_PC      = w_valid ? w_head_entry[31:0]  : '0;
  assign iq_to_dc_inst    = w_valid ? w_head_entry[63:32] : '0;
  assign iq_to_dc_opType  = w_valid ? w_head_entry[70:64] : '0;
  assign iq_to_dc_pred_br = w_valid & w_head_entry[71];
  assign iq_count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue
// Brief    : Directed self-checking bench for inst_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clr_in;
  logic        if_to_iq_ready;
  logic [31:0] if_to_iq_PC;
  logic [6:0]  if_to_iq_opType;
  logic [31:0] if_to_iq_inst;
  logic        if_to_iq_pred_br;
  logic        iq_to_if_stall;
  logic        dc_to_iq_ready;
  logic        iq_to_dc_valid;
  logic [31:0] iq_to_dc_PC;
  logic [6:0]  iq_to_dc_opType;
  logic [31:0] iq_to_dc_inst;
  logic        iq_to_dc_pred_br;
  logic [4:0]  iq_count;

  int n_assert = 0;
  int n_fail   = 0;

  inst_queue #(.DEPTH(16), .PTR_W(4)) u_dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clr_in           (clr_in),
    .if_to_iq_ready   (if_to_iq_ready),
    .if_to_iq_PC      (if_to_iq_PC),
    .if_to_iq_opType  (if_to_iq_opType),
    .if_to_iq_inst    (if_to_iq_inst),
    .if_to_iq_pred_br (if_to_iq_pred_br),
    .iq_to_if_stall   (iq_to_if_stall),
    .dc_to_iq_ready   (dc_to_iq_ready),
    .iq_to_dc_valid   (iq_to_dc_valid),
    .iq_to_dc_PC      (iq_to_dc_PC),
    .iq_to_dc_opType  (iq_to_dc_opType),
    .iq_to_dc_inst    (iq_to_dc_inst),
    .iq_to_dc_pred_br (iq_to_dc_pred_br),
    .iq_count         (iq_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    if_to_iq_ready = 1'b0; if_to_iq_PC = '0; if_to_iq_opType = 7'h13;
    if_to_iq_inst = 32'h0000_0013; if_to_iq_pred_br = 1'b0; dc_to_iq_ready = 1'b0;
    #2;
    check_val("rst_valid", 32'(iq_to_dc_valid), 32'd0);
    check_val("rst_stall", 32'(iq_to_if_stall), 32'd0);
    check_val("rst_count", 32'(iq_count), 32'd0);
    check_val("rst_pc",    iq_to_dc_PC, 32'd0);
    step();
    rst_in = 1'b1;

    // Basic push then ordered pop
    if_to_iq_ready = 1'b1;
    if_to_iq_PC = 32'h00; step();
    if_to_iq_PC = 32'h04; step();
    if_to_iq_PC = 32'h08; step();
    if_to_iq_ready = 1'b0;
    check_val("t1_count", 32'(iq_count), 32'd3);
    check_val("t1_valid", 32'(iq_to_dc_valid), 32'd1);
    check_val("t1_inst",  iq_to_dc_inst, 32'h0000_0013);
    dc_to_iq_ready = 1'b1;
    check_val("t1_pop0", iq_to_dc_PC, 32'h00); step();
    check_val("t1_pop1", iq_to_dc_PC, 32'h04); step();
    check_val("t1_pop2", iq_to_dc_PC, 32'h08); step();
    dc_to_iq_ready = 1'b0;
    check_val("t1_empty_count", 32'(iq_count), 32'd0);
    check_val("t1_empty_valid", 32'(iq_to_dc_valid), 32'd0);
    check_val("t1_empty_pc",    iq_to_dc_PC, 32'd0);

    // Fill to full, hold a stalled push, then release one slot
    if_to_iq_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if_to_iq_PC = 32'h100 + 32'(4 * i);
      if_to_iq_opType = 7'(i);
      if_to_iq_pred_br = 1'(i & 1);
      step();
    end
    check_val("t2_full_stall", 32'(iq_to_if_stall), 32'd1);
    check_val("t2_full_count", 32'(iq_count), 32'd16);
    if_to_iq_PC = 32'h40; if_to_iq_opType = 7'h6f; if_to_iq_pred_br = 1'b1;
    repeat (3) step();
    check_val("t2_hold_count", 32'(iq_count), 32'd16);
    check_val("t2_hold_head",  iq_to_dc_PC, 32'h100);
    check_val("t2_hold_op",    32'(iq_to_dc_opType), 32'd0);
    dc_to_iq_ready = 1'b1; step();
    dc_to_iq_ready = 1'b0;
    check_val("t2_pop_count", 32'(iq_count), 32'd15);
    check_val("t2_pop_stall", 32'(iq_to_if_stall), 32'd0);
    step();
    if_to_iq_ready = 1'b0;
    check_val("t2_refill_count", 32'(iq_count), 32'd16);
    check_val("t2_refill_stall", 32'(iq_to_if_stall), 32'd1);
    dc_to_iq_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check_val("t2_drain_pc", iq_to_dc_PC, 32'h100 + 32'(4 * i));
      check_val("t2_drain_pred", 32'(iq_to_dc_pred_br), 32'(i & 1));
      step();
    end
    check_val("t2_last_pc",   iq_to_dc_PC, 32'h40);
    check_val("t2_last_op",   32'(iq_to_dc_opType), 32'h6f);
    check_val("t2_last_pred", 32'(iq_to_dc_pred_br), 32'd1);
    step();
    dc_to_iq_ready = 1'b0;
    check_val("t2_drained", 32'(iq_count), 32'd0);

    // Steady push+pop at occupancy 5 across pointer wrap
    if_to_iq_ready = 1'b1; if_to_iq_pred_br = 1'b0; if_to_iq_opType = 7'h13;
    for (int i = 0; i < 5; i++) begin
      if_to_iq_PC = 32'h200 + 32'(4 * i);
      step();
    end
    check_val("t3_prefill", 32'(iq_count), 32'd5);
    dc_to_iq_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if_to_iq_PC = 32'h200 + 32'(4 * (k + 5));
      check_val("t3_stream_pc", iq_to_dc_PC, 32'h200 + 32'(4 * k));
      step();
    end
    check_val("t3_count", 32'(iq_count), 32'd5);
    check_val("t3_head",  iq_to_dc_PC, 32'h2A0);

    // Flush with simultaneous push and pop
    dc_to_iq_ready = 1'b0;
    if_to_iq_PC = 32'h2B4; step();
    if_to_iq_PC = 32'h2B8; step();
    check_val("t4_count7", 32'(iq_count), 32'd7);
    clr_in = 1'b1; if_to_iq_PC = 32'h999; dc_to_iq_ready = 1'b1;
    step();
    clr_in = 1'b0; if_to_iq_ready = 1'b0; dc_to_iq_ready = 1'b0;
    check_val("t4_clr_count", 32'(iq_count), 32'd0);
    check_val("t4_clr_valid", 32'(iq_to_dc_valid), 32'd0);
    if_to_iq_ready = 1'b1; if_to_iq_PC = 32'h300; if_to_iq_opType = 7'h63;
    if_to_iq_inst = 32'hFE00_0EE3; if_to_iq_pred_br = 1'b1;
    step();
    if_to_iq_ready = 1'b0;
    check_val("t4_head_pc",   iq_to_dc_PC, 32'h300);
    check_val("t4_head_op",   32'(iq_to_dc_opType), 32'h63);
    check_val("t4_head_inst", iq_to_dc_inst, 32'hFE00_0EE3);
    check_val("t4_head_pred", 32'(iq_to_dc_pred_br), 32'd1);
    check_val("t4_count1",    32'(iq_count), 32'd1);

    // Global enable low freezes everything
    rdy_in = 1'b0;
    if_to_iq_ready = 1'b1; if_to_iq_PC = 32'h304; if_to_iq_opType = 7'h13;
    if_to_iq_inst = 32'h0000_0013; if_to_iq_pred_br = 1'b0; dc_to_iq_ready = 1'b1;
    repeat (4) step();
    check_val("t5_frz_count", 32'(iq_count), 32'd1);
    check_val("t5_frz_pc",    iq_to_dc_PC, 32'h300);
    check_val("t5_frz_valid", 32'(iq_to_dc_valid), 32'd1);
    rdy_in = 1'b1;
    step();
    if_to_iq_ready = 1'b0; dc_to_iq_ready = 1'b0;
    check_val("t5_run_count", 32'(iq_count), 32'd1);
    check_val("t5_run_pc",    iq_to_dc_PC, 32'h304);
    check_val("t5_run_pred",  32'(iq_to_dc_pred_br), 32'd0);

    // Asynchronous reset between edges
    if_to_iq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if_to_iq_PC = 32'h400 + 32'(4 * i);
      step();
    end
    if_to_iq_ready = 1'b0;
    check_val("t6_count9", 32'(iq_count), 32'd9);
    #2;
    rst_in = 1'b0;
    #1;
    check_val("t6_arst_valid", 32'(iq_to_dc_valid), 32'd0);
    check_val("t6_arst_stall", 32'(iq_to_if_stall), 32'd0);
    check_val("t6_arst_count", 32'(iq_count), 32'd0);
    #1;
    rst_in = 1'b1;
    if_to_iq_ready = 1'b1; if_to_iq_PC = 32'h500;
    step();
    if_to_iq_ready = 1'b0;
    check_val("t6_after_pc",    iq_to_dc_PC, 32'h500);
    check_val("t6_after_count", 32'(iq_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
